// File: rtl/sobel_axis_framer.sv
// Sobel magnitude post-processor: runtime-sized AXI-Stream framing, output mode mapping,
// frame resynchronisation with a sticky sync error, and a skid-buffered AXIS master.
module sobel_axis_framer #(
    parameter int WIDTH_P = 16,
    parameter int SAT_W_P = 8,
    parameter int MAX_W_P = 640,
    parameter int MAX_H_P = 480,
    localparam int XW_P = $clog2(MAX_W_P + 1),
    localparam int YW_P = $clog2(MAX_H_P + 1),
    localparam int KW_P = WIDTH_P / 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [XW_P-1:0]    line_w_i,
    input  logic [YW_P-1:0]    frame_h_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH_P-1:0] thresh_i,
    input  logic               err_clr_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               sof_i,
    output logic [WIDTH_P-1:0] tdata_o,
    output logic [KW_P-1:0]    tkeep_o,
    output logic [KW_P-1:0]    tstrb_o,
    output logic               tlast_o,
    output logic               tuser_o,
    output logic               tvalid_o,
    input  logic               tready_i,
    output logic               frame_done_o,
    output logic               sync_err_o
);

    // A beat is packed as {frame_done, tuser, tlast, tdata}.
    localparam int BW_P = WIDTH_P + 3;
    localparam logic [WIDTH_P-1:0] ONES_P    = {WIDTH_P{1'b1}};
    localparam logic [WIDTH_P-1:0] SAT_MAX_P = ONES_P >> (WIDTH_P - SAT_W_P);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    function automatic logic [XW_P-1:0] clamp_w(input logic [XW_P-1:0] v);
        if (v == {XW_P{1'b0}}) begin
            clamp_w = XW_P'(1);
        end else if (v > XW_P'(MAX_W_P)) begin
            clamp_w = XW_P'(MAX_W_P);
        end else begin
            clamp_w = v;
        end
    endfunction

    function automatic logic [YW_P-1:0] clamp_h(input logic [YW_P-1:0] v);
        if (v == {YW_P{1'b0}}) begin
            clamp_h = YW_P'(1);
        end else if (v > YW_P'(MAX_H_P)) begin
            clamp_h = YW_P'(MAX_H_P);
        end else begin
            clamp_h = v;
        end
    endfunction

    function automatic logic [WIDTH_P-1:0] map_pixel(input logic [WIDTH_P-1:0] d,
                                                     input logic [1:0]         mode,
                                                     input logic [WIDTH_P-1:0] thr);
        case (mode)
            2'd0:    map_pixel = d;
            2'd1:    map_pixel = (d > SAT_MAX_P) ? SAT_MAX_P : d;
            2'd2:    map_pixel = (d >= thr) ? ONES_P : {WIDTH_P{1'b0}};
            2'd3:    map_pixel = (d >= thr) ? {WIDTH_P{1'b0}} : ONES_P;
            default: map_pixel = d;
        endcase
    endfunction

    state_t             state_r;
    logic [XW_P-1:0]    x_r, w_r, w_s, pos_x_s;
    logic [YW_P-1:0]    y_r, h_r, h_s, pos_y_s;
    logic [1:0]         mode_r, mode_s;
    logic [WIDTH_P-1:0] thr_r, thr_s;
    logic               sync_err_r, ready_r;
    logic               out_valid_r, skid_valid_r, skid_valid_nxt_s;
    logic [BW_P-1:0]    out_beat_r, skid_beat_r, beat_s;
    logic               acc_s, emit_s, last_s, fdone_s, out_free_s;

    // Accept decode: a start-of-frame beat uses the incoming config, others the shadow copy.
    always_comb begin
        acc_s = valid_i & ready_r;
        if (sof_i) begin
            w_s     = clamp_w(line_w_i);
            h_s     = clamp_h(frame_h_i);
            mode_s  = mode_i;
            thr_s   = thresh_i;
            pos_x_s = {XW_P{1'b0}};
            pos_y_s = {YW_P{1'b0}};
        end else begin
            w_s     = w_r;
            h_s     = h_r;
            mode_s  = mode_r;
            thr_s   = thr_r;
            pos_x_s = x_r;
            pos_y_s = y_r;
        end
        emit_s     = acc_s & (sof_i | (state_r == ST_ACTIVE));
        last_s     = (pos_x_s == (w_s - XW_P'(1)));
        fdone_s    = last_s & (pos_y_s == (h_s - YW_P'(1)));
        beat_s     = {fdone_s, sof_i, last_s, map_pixel(data_i, mode_s, thr_s)};
        out_free_s = ~out_valid_r | tready_i;
        if (out_free_s) begin
            skid_valid_nxt_s = 1'b0;
        end else if (emit_s) begin
            skid_valid_nxt_s = 1'b1;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Framing FSM: position counters, shadow config and sticky sync error.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r    <= ST_IDLE;
            x_r        <= {XW_P{1'b0}};
            y_r        <= {YW_P{1'b0}};
            w_r        <= XW_P'(1);
            h_r        <= YW_P'(1);
            mode_r     <= 2'd0;
            thr_r      <= {WIDTH_P{1'b0}};
            sync_err_r <= 1'b0;
        end else begin
            if (emit_s) begin
                if (sof_i) begin
                    w_r    <= w_s;
                    h_r    <= h_s;
                    mode_r <= mode_s;
                    thr_r  <= thr_s;
                end
                if (last_s) begin
                    x_r <= {XW_P{1'b0}};
                    if (fdone_s) begin
                        y_r     <= {YW_P{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        y_r     <= pos_y_s + YW_P'(1);
                        state_r <= ST_ACTIVE;
                    end
                end else begin
                    x_r     <= pos_x_s + XW_P'(1);
                    y_r     <= pos_y_s;
                    state_r <= ST_ACTIVE;
                end
            end
            // A resync and a clear in the same cycle leave the flag set.
            if (acc_s & sof_i & (state_r == ST_ACTIVE)) begin
                sync_err_r <= 1'b1;
            end else if (err_clr_i) begin
                sync_err_r <= 1'b0;
            end
        end
    end

    // Output register plus one skid slot; upstream ready tracks an empty skid slot.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_r  <= 1'b0;
            out_beat_r   <= {BW_P{1'b0}};
            skid_valid_r <= 1'b0;
            skid_beat_r  <= {BW_P{1'b0}};
            ready_r      <= 1'b0;
        end else begin
            if (out_free_s) begin
                if (skid_valid_r) begin
                    out_beat_r  <= skid_beat_r;
                    out_valid_r <= 1'b1;
                end else if (emit_s) begin
                    out_beat_r  <= beat_s;
                    out_valid_r <= 1'b1;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else if (emit_s) begin
                skid_beat_r <= beat_s;
            end
            skid_valid_r <= skid_valid_nxt_s;
            ready_r      <= ~skid_valid_nxt_s;
        end
    end

    assign tvalid_o     = out_valid_r;
    assign tdata_o      = out_beat_r[WIDTH_P-1:0];
    assign tlast_o      = out_beat_r[WIDTH_P];
    assign tuser_o      = out_beat_r[WIDTH_P+1];
    assign frame_done_o = out_valid_r & tready_i & out_beat_r[WIDTH_P+2];
    assign tkeep_o      = {KW_P{1'b1}};
    assign tstrb_o      = {KW_P{1'b1}};
    assign ready_o      = ready_r;
    assign sync_err_o   = sync_err_r;

endmodule

// File: tb/tb_sobel_axis_framer.sv
// Randomised self-checking bench for sobel_axis_framer against a frame-index reference model.
module tb_sobel_axis_framer;

    localparam int MAXW = 640;
    localparam int MAXH = 480;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [9:0]  line_w_i = 10'd4;
    logic [8:0]  frame_h_i = 9'd2;
    logic [1:0]  mode_i = 2'd0;
    logic [15:0] thresh_i = 16'h0;
    logic        err_clr_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] data_i = 16'h0;
    logic        sof_i = 1'b0;
    logic [15:0] tdata_o;
    logic [1:0]  tkeep_o, tstrb_o;
    logic        tlast_o, tuser_o, tvalid_o;
    logic        tready_i = 1'b1;
    logic        frame_done_o, sync_err_o;

    int n_cmp = 0;
    int n_err = 0;
    bit rand_rdy = 1'b0;

    // Beats are {frame_done, tuser, tlast, tdata}.
    logic [18:0] exp_q[$];
    logic [18:0] got_q[$];

    bit          m_in_frame = 1'b0;
    bit          exp_err = 1'b0;
    int          m_pos = 0, m_w = 1, m_h = 1, m_mode = 0;
    logic [15:0] m_thr = 16'h0;

    sobel_axis_framer dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .line_w_i(line_w_i), .frame_h_i(frame_h_i),
        .mode_i(mode_i), .thresh_i(thresh_i), .err_clr_i(err_clr_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_i(data_i), .sof_i(sof_i), .tdata_o(tdata_o),
        .tkeep_o(tkeep_o), .tstrb_o(tstrb_o), .tlast_o(tlast_o), .tuser_o(tuser_o),
        .tvalid_o(tvalid_o), .tready_i(tready_i), .frame_done_o(frame_done_o),
        .sync_err_o(sync_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i)
        if (rstn_i && tvalid_o && tready_i)
            got_q.push_back({frame_done_o, tuser_o, tlast_o, tdata_o});

    function automatic logic [15:0] ref_pix(input logic [15:0] d, input int mode, input logic [15:0] thr);
        case (mode)
            0:       return d;
            1:       return (d > 16'd255) ? 16'd255 : d;
            2:       return (d >= thr) ? 16'hFFFF : 16'h0000;
            default: return (d >= thr) ? 16'h0000 : 16'hFFFF;
        endcase
    endfunction

    // Model: a frame is W*H beats indexed linearly from the start-of-frame beat.
    function automatic void model_accept(input logic [15:0] d, input bit s);
        int col, row;
        bit last, fd;
        if (s) begin
            if (m_in_frame) exp_err = 1'b1;
            m_w = (int'(line_w_i) == 0) ? 1 : ((int'(line_w_i) > MAXW) ? MAXW : int'(line_w_i));
            m_h = (int'(frame_h_i) == 0) ? 1 : ((int'(frame_h_i) > MAXH) ? MAXH : int'(frame_h_i));
            m_mode = int'(mode_i);
            m_thr = thresh_i;
            m_pos = 0;
            m_in_frame = 1'b1;
        end else if (!m_in_frame) begin
            return;
        end
        col = m_pos % m_w;
        row = m_pos / m_w;
        last = (col == m_w - 1);
        fd = last && (row == m_h - 1);
        exp_q.push_back({fd, (m_pos == 0), last, ref_pix(d, m_mode, m_thr)});
        m_pos++;
        if (m_pos == m_w * m_h) m_in_frame = 1'b0;
    endfunction

    task automatic send_beat(input logic [15:0] d, input bit s);
        bit acc = 1'b0;
        valid_i = 1'b1;
        data_i = d;
        sof_i = s;
        for (int k = 0; k < 100 && !acc; k++) begin
            if (rand_rdy) tready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        sof_i = 1'b0;
        if (acc) model_accept(d, s);
        else begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout ready_o stayed 0, required 1");
        end
    endtask

    task automatic drain();
        tready_i = 1'b1;
        valid_i = 1'b0;
        sof_i = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_i);
            if (k > 4 && got_q.size() >= exp_q.size()) break;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        err_clr_i = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({tvalid_o, tlast_o, tuser_o, ready_o, frame_done_o, sync_err_o, tdata_o} !== 22'h0) begin
            n_err++;
            $display("FAIL reset_outputs got %h required 0", {tvalid_o, tlast_o, tuser_o, ready_o, frame_done_o, sync_err_o, tdata_o});
        end
        n_cmp++;
        if ({tkeep_o, tstrb_o} !== 4'hF) begin
            n_err++; $display("FAIL reset_keep_strb got %h required f", {tkeep_o, tstrb_o});
        end
        #5 rstn_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready_pre_edge got %b required 0", ready_o); end
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready_post_edge got %b required 1", ready_o); end
    endtask

    task automatic test_framing();
        line_w_i = 10'd4; frame_h_i = 9'd2; mode_i = 2'd0; tready_i = 1'b1;
        for (int i = 1; i <= 8; i++) send_beat(16'(i), i == 1);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL framing_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL framing_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        if (got_q.size() == 8) begin
            n_cmp++;
            if (got_q[7] !== {1'b1, 1'b0, 1'b1, 16'd8}) begin n_err++; $display("FAIL framing_last_beat got %h required 50008", got_q[7]); end
        end
        n_cmp++;
        if (sync_err_o !== exp_err) begin n_err++; $display("FAIL framing_sync_err got %b required %b", sync_err_o, exp_err); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_modes();
        logic [15:0] din[6] = '{16'h00FF, 16'h0300, 16'h007F, 16'h0080, 16'h007F, 16'h0080};
        logic [15:0] dexp[6] = '{16'h00FF, 16'h00FF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        for (int m = 1; m <= 3; m++) begin
            mode_i = 2'(m); line_w_i = 10'd2; frame_h_i = 9'd1; thresh_i = 16'h0080;
            send_beat(din[2*m-2], 1'b1);
            mode_i = 2'd0;
            send_beat(din[2*m-1], 1'b0);
        end
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL modes_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL modes_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i][15:0] !== dexp[i]) begin n_err++; $display("FAIL modes_table%0d got %h required %h", i, got_q[i][15:0], dexp[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        int nacc = 0;
        bit acc, s, seen = 1'b0, stable = 1'b1;
        logic [15:0] held = 16'h0, nxt = 16'h0100;
        line_w_i = 10'd8; frame_h_i = 9'd1; mode_i = 2'd0; tready_i = 1'b0;
        valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            s = (nacc == 0);
            data_i = nxt; sof_i = s;
            @(negedge clk_i);
            acc = ready_o;
            if (tvalid_o) begin
                if (!seen) begin held = tdata_o; seen = 1'b1; end
                else if (tdata_o !== held) stable = 1'b0;
            end
            @(posedge clk_i);
            #1;
            if (acc) begin model_accept(nxt, s); nacc++; nxt++; end
        end
        valid_i = 1'b0; sof_i = 1'b0;
        n_cmp++;
        if (nacc != 2) begin n_err++; $display("FAIL bp_accepts got %0d required 2", nacc); end
        n_cmp++;
        if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready got %b required 0", ready_o); end
        n_cmp++;
        if (!(seen && stable && held === 16'h0100)) begin
            n_err++; $display("FAIL bp_stable seen=%b stable=%b held=%h required 1 1 0100", seen, stable, held);
        end
        tready_i = 1'b1;
        while (nacc < 8) begin send_beat(nxt, 1'b0); nxt++; nacc++; end
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_resync();
        line_w_i = 10'd4; frame_h_i = 9'd2; mode_i = 2'd0; tready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send_beat(16'(16'h0200 + i), (i == 1) || (i == 3));
            if (i == 3) begin
                n_cmp++;
                if (sync_err_o !== 1'b1) begin n_err++; $display("FAIL resync_set got %b required 1", sync_err_o); end
            end
        end
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL resync_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL resync_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        clear_err();
        n_cmp++;
        if (sync_err_o !== 1'b0) begin n_err++; $display("FAIL resync_clear got %b required 0", sync_err_o); end
        line_w_i = 10'd1; frame_h_i = 9'd2;
        send_beat(16'h0001, 1'b1);
        err_clr_i = 1'b1;
        send_beat(16'h0002, 1'b1);
        err_clr_i = 1'b0;
        send_beat(16'h0003, 1'b0);
        drain();
        n_cmp++;
        if (sync_err_o !== exp_err) begin n_err++; $display("FAIL resync_set_wins got %b required %b", sync_err_o, exp_err); end
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL resync2_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL resync2_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
        clear_err();
    endtask

    task automatic test_drops_config();
        tready_i = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(16'(16'h0300 + i), 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL drop_idle got %0d beats required 0", got_q.size()); end
        got_q.delete(); exp_q.delete();
        line_w_i = 10'd4; frame_h_i = 9'd1; mode_i = 2'd0;
        send_beat(16'h0401, 1'b1);
        line_w_i = 10'd2; mode_i = 2'd2; thresh_i = 16'h0000;
        for (int i = 2; i <= 4; i++) send_beat(16'(16'h0400 + i), 1'b0);
        line_w_i = 10'd0; frame_h_i = 9'd3; mode_i = 2'd0;
        for (int i = 1; i <= 3; i++) send_beat(16'(16'h0500 + i), i == 1);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL cfg_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL cfg_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (sync_err_o !== exp_err) begin n_err++; $display("FAIL cfg_sync_err got %b required %b", sync_err_o, exp_err); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        bit s;
        logic [15:0] d;
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                line_w_i = ($urandom_range(0, 15) == 0) ? 10'd700 : 10'($urandom_range(0, 5));
                frame_h_i = ($urandom_range(0, 15) == 0) ? 9'd500 : 9'($urandom_range(0, 3));
                mode_i = 2'($urandom_range(0, 3));
                thresh_i = 16'($urandom);
            end
            s = m_in_frame ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 511)) : 16'($urandom);
            send_beat(d, s);
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        end
        rand_rdy = 1'b0;
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (sync_err_o !== exp_err) begin n_err++; $display("FAIL rand_sync_err got %b required %b", sync_err_o, exp_err); end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_async_reset();
        line_w_i = 10'd4; frame_h_i = 9'd2; mode_i = 2'd0; tready_i = 1'b0;
        send_beat(16'h0601, 1'b1);
        n_cmp++;
        if (tvalid_o !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b required 1", tvalid_o); end
        send_beat(16'h0602, 1'b1);
        #2 rstn_i = 1'b0;
        #1;
        n_cmp++;
        if ({tvalid_o, tlast_o, tuser_o, ready_o, frame_done_o, sync_err_o, tdata_o} !== 22'h0) begin
            n_err++;
            $display("FAIL arst_outputs got %h required 0", {tvalid_o, tlast_o, tuser_o, ready_o, frame_done_o, sync_err_o, tdata_o});
        end
        m_in_frame = 1'b0; exp_err = 1'b0;
        got_q.delete(); exp_q.delete();
        #3 rstn_i = 1'b1;
        tready_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b required 1", ready_o); end
        for (int i = 0; i < 3; i++) send_beat(16'(16'h0700 + i), 1'b0);
        line_w_i = 10'd2; frame_h_i = 9'd1;
        send_beat(16'h0801, 1'b1);
        send_beat(16'h0802, 1'b0);
        drain();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL arst_count got %0d required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL arst_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_cmp++;
        if (sync_err_o !== 1'b0) begin n_err++; $display("FAIL arst_sync_err got %b required 0", sync_err_o); end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_framing();
        test_modes();
        test_backpressure();
        test_resync();
        test_drops_config();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
